ret_stack: RTL and testbench

RET_STACK -- requirements
Module: ret_stack

---
 rtl/sisc_pkg.sv | 23 ++
 rtl/ret_stack_mem.sv | 42 ++++
 rtl/ret_stack.sv | 151 +++++++++++++++
 tb/tb_ret_stack.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// sisc_pkg -- constants and types shared by the program counter and the
// return-address stack.
//
// Contents:
//   ADDR_W          program-counter / return-address width (16)
//   RET_STACK_DEPTH number of return-address entries (8)
//   addr_t          program-address type
//   ptr_step        helper: advance or retreat a circular pointer

package sisc_pkg;

  localparam int ADDR_W          = 16;
  localparam int RET_STACK_DEPTH = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  // Move a 4-bit circular pointer one slot up (dir=1) or down (dir=0).
  // Power-of-two depths wrap naturally through truncation.
  function automatic logic [3:0] ptr_step(input logic [3:0] p, input logic dir);
    return dir ? p + 4'd1 : p - 4'd1;
  endfunction

endpackage

// File: rtl/ret_stack_mem.sv
// ret_stack_mem -- entry storage for the return-address stack.
// DEPTH x AW registers with one synchronous write port and one
// asynchronous read port. Contents are not reset.
//
// Ports:
//   clk    in   system clock, posedge active
//   we     in   write enable
//   waddr  in   write index, $clog2(DEPTH) bits
//   wdata  in   write data, AW bits
//   raddr  in   read index, $clog2(DEPTH) bits
//   rdata  out  data at raddr, combinational

module ret_stack_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [AW-1:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [AW-1:0]              rdata
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] entry_q [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (we && (waddr == PW'(gi))) begin
          entry_q[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = entry_q[raddr];

endmodule

// File: rtl/ret_stack.sv
// ret_stack -- circular return-address stack for subroutine call/return.
// A push at full overwrites the oldest entry; a pop when empty is ignored.
// Optional sticky error flags are built when RET_STACK_ERR_FLAGS_EN is
// defined; otherwise ovf/unf are tied low and err_clr is ignored.
//
// Ports:
//   clk        in   system clock, posedge active
//   rst_f      in   synchronous reset, active low
//   push       in   call: save push_addr
//   pop        in   return: discard top entry
//   push_addr  in   return address to save (PC+1)
//   ret_addr   out  top-of-stack address, zero when empty
//   ret_valid  out  stack holds at least one entry
//   full       out  count == DEPTH
//   count      out  number of valid entries
//   err_clr    in   clears sticky ovf/unf
//   ovf        out  sticky: push while full
//   unf        out  sticky: pop while empty

module ret_stack
  import sisc_pkg::*;
#(
  parameter int DEPTH = RET_STACK_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_f,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_addr,
  output logic [AW-1:0]            ret_addr,
  output logic                     ret_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     err_clr,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // ptr_q indexes the current top entry; it is meaningful only when count>0.
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty;
  logic          is_full;
  logic          mem_we;
  logic [PW-1:0] mem_waddr;
  logic [AW-1:0] top_data;

  assign empty   = (count_q == '0);
  assign is_full = (count_q == CW'(DEPTH));

  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10: begin
        // At full the slot above the top is the oldest entry, so the same
        // write both grows the stack and, when full, overwrites the oldest.
        mem_we = 1'b1;
        ptr_d  = ptr_q + PW'(1);
        if (!is_full) count_d = count_q + CW'(1);
      end
      2'b01: begin
        if (!empty) begin
          ptr_d   = ptr_q - PW'(1);
          count_d = count_q - CW'(1);
        end
      end
      2'b11: begin
        mem_we = 1'b1;
        if (empty) begin
          ptr_d   = ptr_q + PW'(1);
          count_d = CW'(1);
        end else begin
          mem_waddr = ptr_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  ret_stack_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we & rst_f),
    .waddr (mem_waddr),
    .wdata (push_addr),
    .raddr (ptr_q),
    .rdata (top_data)
  );

  // Stale storage is masked so an empty stack always presents zero.
  assign ret_addr  = empty ? '0 : top_data;
  assign ret_valid = !empty;
  assign full      = is_full;
  assign count     = count_q;

`ifdef RET_STACK_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Clear first, then let a same-cycle error re-set the flag.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (push && !pop && is_full) ovf_d = 1'b1;
    if (pop && empty)            unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_ret_stack.sv
// tb_ret_stack -- directed self-checking bench for ret_stack.
// Expected flag values follow RET_STACK_ERR_FLAGS_EN: with the macro
// defined errors set the sticky flags, otherwise the flags stay low.

module tb_ret_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 16;

`ifdef RET_STACK_ERR_FLAGS_EN
  localparam logic FE = 1'b1;
`else
  localparam logic FE = 1'b0;
`endif

  logic          clk;
  logic          rst_f;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] ret_addr;
  logic          ret_valid;
  logic          full;
  logic [3:0]    count;
  logic          err_clr;
  logic          ovf;
  logic          unf;

  int errors = 0;
  int checks = 0;

  ret_stack #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .ret_addr  (ret_addr),
    .ret_valid (ret_valid),
    .full      (full),
    .count     (count),
    .err_clr   (err_clr),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Apply the current inputs across one posedge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    rst_f   = 1'b1;
  endtask

  task automatic do_push(input logic [AW-1:0] a);
    push = 1'b1; push_addr = a; tick();
  endtask

  task automatic do_pop();
    pop = 1'b1; tick();
  endtask

  task automatic do_reset();
    rst_f = 1'b0; tick();
  endtask

  logic [AW-1:0] exp_top [8];

  initial begin
    rst_f = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_addr = '0;
    #2;
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(ret_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_addr", 32'(ret_addr), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);

    // Single push
    do_push(16'h0011);
    chk("p1_addr", 32'(ret_addr), 32'h0011);
    chk("p1_count", 32'(count), 1);
    chk("p1_valid", 32'(ret_valid), 1);
    do_pop();
    chk("p1_pop_count", 32'(count), 0);

    // Fill, overflow, drain
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_push(16'h0100 + 16'(i));
      chk($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf", 32'(ovf), 0);
    chk("fill_top", 32'(ret_addr), 32'h0107);
    do_push(16'h0200);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_flag", 32'(ovf), 32'(FE));
    exp_top[0] = 16'h0200;
    for (int i = 1; i < 8; i++) exp_top[i] = 16'h0108 - 16'(i);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_top", i), 32'(ret_addr), 32'(exp_top[i]));
      do_pop();
      chk($sformatf("drain%0d_count", i), 32'(count), 32'(7 - i));
    end
    chk("drain_valid", 32'(ret_valid), 0);
    chk("drain_addr", 32'(ret_addr), 0);
    chk("drain_full", 32'(full), 0);
    chk("drain_unf", 32'(unf), 0);
    err_clr = 1'b1; tick();
    chk("clr_ovf", 32'(ovf), 0);

    // Underflow, clear, and clear-vs-error priority
    do_pop();
    chk("unf_flag", 32'(unf), 32'(FE));
    chk("unf_count", 32'(count), 0);
    chk("unf_addr", 32'(ret_addr), 0);
    err_clr = 1'b1; tick();
    chk("unf_clr", 32'(unf), 0);
    do_pop();
    err_clr = 1'b1; pop = 1'b1; tick();
    chk("unf_prio", 32'(unf), 32'(FE));
    err_clr = 1'b1; tick();
    chk("unf_clr2", 32'(unf), 0);

    // Replace top with simultaneous push/pop
    do_push(16'h0A00);
    do_push(16'h0B00);
    push = 1'b1; pop = 1'b1; push_addr = 16'h0C00; tick();
    chk("repl_addr", 32'(ret_addr), 32'h0C00);
    chk("repl_count", 32'(count), 2);
    chk("repl_unf", 32'(unf), 0);
    do_pop();
    chk("repl_pop_addr", 32'(ret_addr), 32'h0A00);
    chk("repl_pop_count", 32'(count), 1);
    do_pop();

    // Push/pop together on an empty stack
    push = 1'b1; pop = 1'b1; push_addr = 16'h0D00; tick();
    chk("pp0_count", 32'(count), 1);
    chk("pp0_addr", 32'(ret_addr), 32'h0D00);
    chk("pp0_unf", 32'(unf), 32'(FE));

    // Mid-sequence reset overrides a push in the same cycle
    do_push(16'h0E01);
    do_push(16'h0E02);
    do_push(16'h0E03);
    rst_f = 1'b0; push = 1'b1; push_addr = 16'h0E04; tick();
    chk("mrst_count", 32'(count), 0);
    chk("mrst_valid", 32'(ret_valid), 0);
    chk("mrst_addr", 32'(ret_addr), 0);
    chk("mrst_ovf", 32'(ovf), 0);
    chk("mrst_unf", 32'(unf), 0);
    do_push(16'h0077);
    chk("post_rst_addr", 32'(ret_addr), 32'h0077);
    chk("post_rst_count", 32'(count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
